// File: rtl/arbiter_n_if.sv
`default_nettype none
//============================================================================
// Module   : arbiter_n_if
// Brief    : Bundled master-side and slave-side Wishbone signals of arbiter_n
// Revision : 1.0
//============================================================================
interface arbiter_n_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
  logic [NUM_MASTERS*3-1:0]          m_cti_i;
  logic [DATA_WIDTH-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;
  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]             s_dat_o;
  logic [SEL_WIDTH-1:0]              s_sel_o;
  logic [2:0]                        s_cti_o;
  logic [1:0]                        s_bte_o;
  logic [DATA_WIDTH-1:0]             s_dat_i;
  logic                              s_ack_i;
  logic                              s_err_i;
  logic [NUM_MASTERS-1:0]            grant_o;

  // Arbiter view: it is the slave of the master buses and drives the shared bus
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    output grant_o
  );

  // Environment view: the masters plus the shared slave device
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    input  grant_o
  );
endinterface
`default_nettype wire

// File: rtl/arbiter_n.sv
`default_nettype none
//============================================================================
// Module   : arbiter_n
// Brief    : N-way Wishbone arbiter, fixed or round-robin, with ACK watchdog
// Revision : 1.0
//============================================================================
module arbiter_n #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT     = 0
) (
  input  wire logic  clock_i,
  input  wire logic  reset_n_i,
  arbiter_n_if.slave bus
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDXW      = $clog2(NUM_MASTERS);
  localparam logic [IDXW-1:0] c_LAST  = IDXW'(NUM_MASTERS - 1);
  localparam logic [IDXW:0]   c_N_EXT = (IDXW+1)'(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] r_grant;
  logic [IDXW-1:0]        r_ptr;

  logic                   w_owner_cyc;
  logic                   w_owner_stb;
  logic                   w_s_stb;
  logic                   w_we;
  logic [ADDR_WIDTH-1:0]  w_adr;
  logic [DATA_WIDTH-1:0]  w_dat;
  logic [SEL_WIDTH-1:0]   w_sel;
  logic [2:0]             w_cti;
  logic                   w_wd_err;

  logic [IDXW-1:0]        w_start;
  logic [IDXW:0]          w_j;
  logic [IDXW-1:0]        w_win_idx;
  logic                   w_win_found;
  logic [NUM_MASTERS-1:0] w_win_onehot;

  // One-hot grant makes an AND-OR mux; everything reads zero while idle
  always_comb begin
    w_owner_cyc = |(r_grant & bus.m_cyc_i);
    w_owner_stb = |(r_grant & bus.m_stb_i);
    w_we        = |(r_grant & bus.m_we_i);
    w_adr       = '0;
    w_dat       = '0;
    w_sel       = '0;
    w_cti       = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_adr = w_adr | (bus.m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{r_grant[i]}});
      w_dat = w_dat | (bus.m_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
      w_sel = w_sel | (bus.m_sel_i[i*SEL_WIDTH +: SEL_WIDTH] & {SEL_WIDTH{r_grant[i]}});
      w_cti = w_cti | (bus.m_cti_i[i*3 +: 3] & {3{r_grant[i]}});
    end
  end

  assign w_s_stb     = w_owner_cyc & w_owner_stb;

  assign bus.s_cyc_o = w_owner_cyc;
  assign bus.s_stb_o = w_s_stb;
  assign bus.s_we_o  = w_we;
  assign bus.s_adr_o = w_adr;
  assign bus.s_dat_o = w_dat;
  assign bus.s_sel_o = w_sel;
  assign bus.s_cti_o = w_cti;
  assign bus.s_bte_o = 2'b00;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = r_grant & {NUM_MASTERS{bus.s_ack_i}};
  assign bus.m_err_o = r_grant & {NUM_MASTERS{bus.s_err_i | w_wd_err}};
  assign bus.grant_o = r_grant;

  // Search starts one past the last owner in round-robin mode, at 0 otherwise
  always_comb begin
    if ((ROUND_ROBIN != 0) && (r_ptr != c_LAST)) begin
      w_start = r_ptr + IDXW'(1);
    end else begin
      w_start = '0;
    end
    w_j          = '0;
    w_win_found  = 1'b0;
    w_win_idx    = '0;
    w_win_onehot = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_j = {1'b0, w_start} + (IDXW+1)'(k);
      if (w_j >= c_N_EXT) begin
        w_j = w_j - c_N_EXT;
      end
      if (!w_win_found && bus.m_cyc_i[w_j[IDXW-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_j[IDXW-1:0];
      end
    end
    if (w_win_found) begin
      w_win_onehot[w_win_idx] = 1'b1;
    end
  end

  // Clearing the grant for a cycle before re-arbitrating forces the idle gap
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_grant <= '0;
      r_ptr   <= c_LAST;
    end else if (r_grant == '0) begin
      if (w_win_found) begin
        r_grant <= w_win_onehot;
        r_ptr   <= w_win_idx;
      end
    end else if (!w_owner_cyc) begin
      r_grant <= '0;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [WDW-1:0] c_WD_LAST = WDW'(TIMEOUT - 1);

      logic [WDW-1:0] r_wd_cnt;
      logic           r_wd_err;

      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          r_wd_cnt <= '0;
          r_wd_err <= 1'b0;
        end else begin
          r_wd_err <= 1'b0;
          if (w_s_stb && !bus.s_ack_i && !bus.s_err_i) begin
            if (r_wd_cnt == c_WD_LAST) begin
              r_wd_cnt <= '0;
              r_wd_err <= 1'b1;
            end else begin
              r_wd_cnt <= r_wd_cnt + WDW'(1);
            end
          end else begin
            r_wd_cnt <= '0;
          end
        end
      end

      assign w_wd_err = r_wd_err;
    end else begin : g_no_wd
      assign w_wd_err = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire
